// File: rtl/membus_mon_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// membus_mon_pkg : shared types, defaults and sizing helper for the MemBus monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
package membus_mon_pkg;

   typedef enum logic [1:0] {
      CMD_TIMEOUT = 2'd0,
      RSP_TIMEOUT = 2'd1,
      SPURIOUS    = 2'd2,
      OVERFLOW    = 2'd3
   } viol_kind_e;

   localparam int NUM_VIOL            = 4;
   localparam int DEF_NUM_PORTS       = 2;
   localparam int DEF_MAX_CMD_WAIT    = 4;
   localparam int DEF_MAX_RSP_WAIT    = 4;
   localparam int DEF_MAX_OUTSTANDING = 1;

   // Bits needed to hold any value 0..max(a,b).
   function automatic int clog2_of_max(input int a, input int b);
      return (a > b) ? $clog2(a + 1) : $clog2(b + 1);
   endfunction

endpackage : membus_mon_pkg
`default_nettype wire

// File: rtl/membus_port_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// membus_port_monitor : counters, rule checks and sticky flags for one MemBus port
// Revision: 1.0
// ---------------------------------------------------------------------------
module membus_port_monitor
   import membus_mon_pkg::*;
#(
   parameter int MAX_CMD_WAIT    = DEF_MAX_CMD_WAIT,
   parameter int MAX_RSP_WAIT    = DEF_MAX_RSP_WAIT,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int WAIT_W          = clog2_of_max(MAX_CMD_WAIT, MAX_RSP_WAIT),
   parameter int OCNT_W          = clog2_of_max(MAX_OUTSTANDING, 0)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                cmd_valid_i,
   input  logic                cmd_ready_i,
   input  logic                cmd_write_i,
   input  logic                rsp_valid_i,
   input  logic                rsp_ready_i,
   output logic [OCNT_W-1:0]   outstanding_o,
   output logic                legal_o,
   output logic [NUM_VIOL-1:0] err_o
);

   localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(MAX_OUTSTANDING);
   localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);
   localparam logic [WAIT_W-1:0] CMD_MAX  = WAIT_W'(MAX_CMD_WAIT);
   localparam logic [WAIT_W-1:0] RSP_MAX  = WAIT_W'(MAX_RSP_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
   logic [WAIT_W-1:0]   cmd_wait_q, cmd_wait_d;
   logic [WAIT_W-1:0]   rsp_wait_q, rsp_wait_d;
   logic [NUM_VIOL-1:0] err_q, err_d;
   logic [NUM_VIOL-1:0] viol;
   logic                accept, retire, cmd_stall, rsp_pending;

   always_comb begin
      accept      = cmd_valid_i & cmd_ready_i & ~cmd_write_i;
      retire      = rsp_valid_i & rsp_ready_i;
      cmd_stall   = cmd_valid_i & ~cmd_ready_i;
      rsp_pending = (ocnt_q != '0) & ~retire;

      viol              = '0;
      viol[CMD_TIMEOUT] = cmd_stall & (cmd_wait_q == CMD_MAX);
      viol[RSP_TIMEOUT] = rsp_pending & (rsp_wait_q == RSP_MAX);
      viol[SPURIOUS]    = rsp_valid_i & (ocnt_q == '0) & ~accept;
      viol[OVERFLOW]    = accept & (ocnt_q == OCNT_MAX) & ~retire;

      // Count saturates at both ends: overflow holds at max, spurious holds at 0.
      ocnt_d = ocnt_q;
      if (accept && !retire && ocnt_q != OCNT_MAX) begin
         ocnt_d = ocnt_q + OCNT_ONE;
      end else if (retire && !accept && ocnt_q != '0) begin
         ocnt_d = ocnt_q - OCNT_ONE;
      end

      cmd_wait_d = '0;
      if (cmd_stall) begin
         cmd_wait_d = (cmd_wait_q == CMD_MAX) ? cmd_wait_q : cmd_wait_q + WAIT_ONE;
      end

      rsp_wait_d = '0;
      if (rsp_pending) begin
         rsp_wait_d = (rsp_wait_q == RSP_MAX) ? rsp_wait_q : rsp_wait_q + WAIT_ONE;
      end

      err_d = err_q | viol;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ocnt_q     <= '0;
         cmd_wait_q <= '0;
         rsp_wait_q <= '0;
         err_q      <= '0;
      end else begin
         ocnt_q     <= ocnt_d;
         cmd_wait_q <= cmd_wait_d;
         rsp_wait_q <= rsp_wait_d;
         err_q      <= err_d;
      end
   end

   assign outstanding_o = ocnt_q;
   assign legal_o       = ~|viol;
   assign err_o         = err_q;

endmodule : membus_port_monitor
`default_nettype wire

// File: rtl/membus_fairness_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// membus_fairness_monitor : observe-only protocol/fairness monitor for NUM_PORTS MemBus channels
// Revision: 1.0
// ---------------------------------------------------------------------------
module membus_fairness_monitor
   import membus_mon_pkg::*;
#(
   parameter  int NUM_PORTS       = DEF_NUM_PORTS,
   parameter  int MAX_CMD_WAIT    = DEF_MAX_CMD_WAIT,
   parameter  int MAX_RSP_WAIT    = DEF_MAX_RSP_WAIT,
   parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   localparam int WAIT_W          = clog2_of_max(MAX_CMD_WAIT, MAX_RSP_WAIT),
   localparam int OCNT_W          = clog2_of_max(MAX_OUTSTANDING, 0)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_PORTS-1:0]          cmd_valid,
   input  logic [NUM_PORTS-1:0]          cmd_ready,
   input  logic [NUM_PORTS-1:0]          cmd_write,
   input  logic [NUM_PORTS-1:0]          rsp_valid,
   input  logic [NUM_PORTS-1:0]          rsp_ready,
   output logic [NUM_PORTS*OCNT_W-1:0]   outstanding,
   output logic [NUM_PORTS-1:0]          legal,
   output logic [NUM_PORTS-1:0]          err_cmd_timeout,
   output logic [NUM_PORTS-1:0]          err_rsp_timeout,
   output logic [NUM_PORTS-1:0]          err_spurious_rsp,
   output logic [NUM_PORTS-1:0]          err_overflow,
   output logic                          any_error
);

   logic any_error_q, any_error_d;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [NUM_VIOL-1:0] err;

      membus_port_monitor #(
         .MAX_CMD_WAIT    (MAX_CMD_WAIT),
         .MAX_RSP_WAIT    (MAX_RSP_WAIT),
         .MAX_OUTSTANDING (MAX_OUTSTANDING),
         .WAIT_W          (WAIT_W),
         .OCNT_W          (OCNT_W)
      ) u_port (
         .clk_i         (clk),
         .reset_i       (reset),
         .cmd_valid_i   (cmd_valid[i]),
         .cmd_ready_i   (cmd_ready[i]),
         .cmd_write_i   (cmd_write[i]),
         .rsp_valid_i   (rsp_valid[i]),
         .rsp_ready_i   (rsp_ready[i]),
         .outstanding_o (outstanding[i*OCNT_W +: OCNT_W]),
         .legal_o       (legal[i]),
         .err_o         (err)
      );

      assign err_cmd_timeout[i]  = err[CMD_TIMEOUT];
      assign err_rsp_timeout[i]  = err[RSP_TIMEOUT];
      assign err_spurious_rsp[i] = err[SPURIOUS];
      assign err_overflow[i]     = err[OVERFLOW];
   end

   // Reduction of the already-registered flags, so any_error trails them by one cycle.
   assign any_error_d = |{err_cmd_timeout, err_rsp_timeout, err_spurious_rsp, err_overflow};

   always_ff @(posedge clk) begin
      if (reset) begin
         any_error_q <= 1'b0;
      end else begin
         any_error_q <= any_error_d;
      end
   end

   assign any_error = any_error_q;

endmodule : membus_fairness_monitor
`default_nettype wire

// File: tb/tb_membus_fairness_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_membus_fairness_monitor : directed + randomized bench with run-length reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_membus_fairness_monitor;

   localparam int NP  = 2;
   localparam int MCW = 4;
   localparam int MRW = 4;
   localparam int MO  = 2;
   localparam int OW  = $clog2(MO + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] cv, cr, cw, rv, rr;
   logic [NP*OW-1:0] outstanding;
   logic [NP-1:0] legal, e_cmd, e_rsp, e_spur, e_ovf;
   logic          any_error;

   int total = 0;
   int bad   = 0;

   // Reference model: outstanding reads and lengths of the current stall/wait runs.
   int            m_out [NP];
   int            m_cw  [NP];
   int            m_rw  [NP];
   logic [NP-1:0] m_ecmd, m_ersp, m_espur, m_eovf;
   logic          m_any;

   always #5 clk = ~clk;

   membus_fairness_monitor #(
      .NUM_PORTS       (NP),
      .MAX_CMD_WAIT    (MCW),
      .MAX_RSP_WAIT    (MRW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk              (clk),
      .reset            (rst),
      .cmd_valid        (cv),
      .cmd_ready        (cr),
      .cmd_write        (cw),
      .rsp_valid        (rv),
      .rsp_ready        (rr),
      .outstanding      (outstanding),
      .legal            (legal),
      .err_cmd_timeout  (e_cmd),
      .err_rsp_timeout  (e_rsp),
      .err_spurious_rsp (e_spur),
      .err_overflow     (e_ovf),
      .any_error        (any_error)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   task automatic viols(input int p, output bit vc, output bit vr, output bit vs, output bit vo);
      bit acc, ret;
      acc = cv[p] && cr[p] && !cw[p];
      ret = rv[p] && rr[p];
      vc  = cv[p] && !cr[p] && (m_cw[p] >= MCW);
      vr  = (m_out[p] > 0) && !ret && (m_rw[p] >= MRW);
      vs  = rv[p] && (m_out[p] == 0) && !acc;
      vo  = acc && (m_out[p] == MO) && !ret;
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_out[p] = 0; m_cw[p] = 0; m_rw[p] = 0;
      end
      m_ecmd = '0; m_ersp = '0; m_espur = '0; m_eovf = '0; m_any = 1'b0;
   endtask

   task automatic check_all();
      logic [NP-1:0]    x_legal;
      logic [NP*OW-1:0] x_out;
      bit vc, vr, vs, vo;
      for (int p = 0; p < NP; p++) begin
         viols(p, vc, vr, vs, vo);
         x_legal[p] = !(vc || vr || vs || vo);
         x_out[p*OW +: OW] = OW'(m_out[p]);
      end
      chk("legal",            32'(legal),       32'(x_legal));
      chk("outstanding",      32'(outstanding), 32'(x_out));
      chk("err_cmd_timeout",  32'(e_cmd),       32'(m_ecmd));
      chk("err_rsp_timeout",  32'(e_rsp),       32'(m_ersp));
      chk("err_spurious_rsp", 32'(e_spur),      32'(m_espur));
      chk("err_overflow",     32'(e_ovf),       32'(m_eovf));
      chk("any_error",        32'(any_error),   32'(m_any));
   endtask

   task automatic model_step();
      bit vc, vr, vs, vo, acc, ret;
      logic old_any_flag;
      if (rst) begin
         model_reset();
      end else begin
         old_any_flag = |{m_ecmd, m_ersp, m_espur, m_eovf};
         for (int p = 0; p < NP; p++) begin
            viols(p, vc, vr, vs, vo);
            acc = cv[p] && cr[p] && !cw[p];
            ret = rv[p] && rr[p];
            m_ecmd[p]  = m_ecmd[p]  | vc;
            m_ersp[p]  = m_ersp[p]  | vr;
            m_espur[p] = m_espur[p] | vs;
            m_eovf[p]  = m_eovf[p]  | vo;
            m_rw[p] = ((m_out[p] > 0) && !ret) ? m_rw[p] + 1 : 0;
            m_cw[p] = (cv[p] && !cr[p]) ? m_cw[p] + 1 : 0;
            if (acc && !ret && m_out[p] < MO) m_out[p]++;
            else if (ret && !acc && m_out[p] > 0) m_out[p]--;
         end
         m_any = old_any_flag;
      end
   endtask

   // One clock: compare mid-cycle, advance model on the edge, return at negedge.
   task automatic cyc();
      #1 check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      cv = '0; cr = '0; cw = '0; rv = '0; rr = '0;
   endtask

   task automatic do_reset();
      idle(); rst = 1'b1; cyc(); rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outstanding", 32'(outstanding), 32'd0);
      chk("reset_flags", 32'({e_cmd, e_rsp, e_spur, e_ovf}), 32'd0);
      chk("reset_any", 32'(any_error), 32'd0);

      // 1: command stall of exactly MCW cycles is legal, MCW+1 is not.
      cv[0] = 1; cw[0] = 1; cr[0] = 0;
      repeat (4) cyc();
      cr[0] = 1; cyc();
      idle(); cyc();
      chk("t1_no_cmd_flag", 32'(e_cmd), 32'd0);
      cv[0] = 1; cw[0] = 1; cr[0] = 0;
      repeat (4) cyc();
      #1 chk("t1_legal_low", 32'(legal), 32'b10);
      cyc();
      idle();
      #1 chk("t1_cmd_flag", 32'(e_cmd), 32'b01);
      chk("t1_any_lag", 32'(any_error), 32'd0);
      cyc();
      #1 chk("t1_any_set", 32'(any_error), 32'd1);
      cyc();
      do_reset();

      // 2: response 4 cycles after accept is fine, 6 cycles times out.
      cv[0] = 1; cr[0] = 1; cyc();
      idle();
      #1 chk("t2_out_one", 32'(outstanding), 32'd1);
      repeat (3) cyc();
      rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t2_out_zero", 32'(outstanding), 32'd0);
      chk("t2_no_rsp_flag", 32'(e_rsp), 32'd0);
      cv[0] = 1; cr[0] = 1; cyc();
      idle(); repeat (5) cyc();
      rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t2_rsp_flag", 32'(e_rsp), 32'b01);
      do_reset();

      // 3: spurious response on port 1; zero-latency response is legal.
      rv[1] = 1;
      #1 chk("t3_legal1_low", 32'(legal), 32'b01);
      cyc();
      idle(); cyc();
      chk("t3_spur_flag", 32'(e_spur), 32'b10);
      chk("t3_out_zero", 32'(outstanding), 32'd0);
      do_reset();
      cv[0] = 1; cr[0] = 1; rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t3_zero_lat_ok", 32'({e_spur, outstanding}), 32'd0);

      // 4: overflow at MO=2, accept+retire at max is neutral.
      cv[0] = 1; cr[0] = 1; cyc(); cyc();
      rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t4_both_at_max", 32'({e_ovf, outstanding}), 32'({2'b00, 2'd0, 2'd2}));
      do_reset();
      cv[0] = 1; cr[0] = 1; cyc();
      #1 chk("t4_cnt1", 32'(outstanding), 32'd1);
      cyc();
      #1 chk("t4_cnt2", 32'(outstanding), 32'd2);
      cyc();
      idle();
      #1 chk("t4_cnt_hold", 32'(outstanding), 32'd2);
      chk("t4_ovf_flag", 32'(e_ovf), 32'b01);
      cyc();
      do_reset();

      // 5: writes do not count; a later response is spurious.
      cv[0] = 1; cr[0] = 1; cw[0] = 1; cyc();
      idle(); cyc();
      chk("t5_write_no_cnt", 32'(outstanding), 32'd0);
      rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t5_write_spur", 32'(e_spur), 32'b01);
      do_reset();

      // 6: reset discards outstanding reads and flags.
      cv[0] = 1; cr[0] = 1; rv[1] = 1; cyc();
      idle(); cyc();
      do_reset();
      #1 chk("t6_post_reset", 32'({outstanding, e_cmd, e_rsp, e_spur, e_ovf, any_error}), 32'd0);
      rv[0] = 1; rr[0] = 1; cyc();
      idle(); cyc();
      chk("t6_spur_port0", 32'(e_spur), 32'b01);
      do_reset();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int p = 0; p < NP; p++) begin
            cv[p] = ($urandom_range(0, 99) < 55);
            cr[p] = ($urandom_range(0, 99) < 45);
            cw[p] = ($urandom_range(0, 99) < 30);
            if (m_out[p] > 0) rv[p] = ($urandom_range(0, 99) < 45);
            else              rv[p] = ($urandom_range(0, 99) < 4);
            rr[p] = ($urandom_range(0, 99) < 75);
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_membus_fairness_monitor
`default_nettype wire
